release_envelope_stage: RTL and testbench

Parametrised release stage of the ADSR envelope chain. On note-off it attenuates the incoming sample stream by a right-shift that starts at the sustain level and grows by one step per programmable rate tick until the output is silent. The rate divider is internal, so the stage no longer needs a separate release clock. The block sits between the sustain stage and the voice mixer and reports completion to the voice allocator.

---
 rtl/envelope_pkg.sv | 16 +
 rtl/release_envelope_stage_if.sv | 30 +++
 rtl/release_rate_divider.sv | 33 +++
 rtl/release_envelope_stage.sv | 115 +++++++++++
 tb/tb_release_envelope_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/envelope_pkg.sv
// Shared definitions for the ADSR envelope stages.
//   env_state_e    : stage state (IDLE pass-through, RELEASE stepping, DONE silent)
//   ENV_DATA_W     : default sample width
//   ENV_END_SHIFT  : default shift at which a stage is fully silent (DATA_W+1)
package envelope_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } env_state_e;

  localparam int unsigned ENV_DATA_W    = 20;
  localparam int unsigned ENV_END_SHIFT = ENV_DATA_W + 1;

endpackage

// File: rtl/release_envelope_stage_if.sv
// Control, sample and status bundle of the release envelope stage.
//   master : voice controller / sustain side (drives control and samples in)
//   slave  : the release stage (drives attenuated samples and status)
interface release_envelope_stage_if #(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned RATE_W  = 16
);
  logic               start;
  logic               gate_on;
  logic [SHIFT_W-1:0] start_level;
  logic [RATE_W-1:0]  rate;
  logic               in_valid;
  logic [DATA_W-1:0]  in;
  logic [DATA_W-1:0]  out;
  logic               out_valid;
  logic               active;
  logic               end_release;
  logic               done_pulse;

  modport master (
    output start, gate_on, start_level, rate, in_valid, in,
    input  out, out_valid, active, end_release, done_pulse
  );

  modport slave (
    input  start, gate_on, start_level, rate, in_valid, in,
    output out, out_valid, active, end_release, done_pulse
  );
endinterface

// File: rtl/release_rate_divider.sv
// Programmable step-rate divider shared by the envelope stages.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : restart the count from zero
//   i_enable   : count this cycle
//   i_rate     : cycles per tick minus one
//   o_tick_c   : combinational single-cycle tick when the count reaches i_rate
module release_rate_divider #(
  parameter int unsigned RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_tick_c
);

  logic [RATE_W-1:0] r_cnt;

  assign o_tick_c = i_enable && !i_clear && (r_cnt == i_rate);

  // Count wraps to zero on the tick, so one step every i_rate+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == i_rate) ? '0 : r_cnt + RATE_W'(1);
    end
  end

endmodule

// File: rtl/release_envelope_stage.sv
// Release stage of the ADSR chain: attenuates samples by a right shift that
// starts at the sustain level and grows one step per rate tick until silent.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of release_envelope_stage_if (control, samples,
//                active/end_release levels and done_pulse)
module release_envelope_stage
  import envelope_pkg::*;
#(
  parameter int unsigned DATA_W    = ENV_DATA_W,
  parameter int unsigned SHIFT_W   = 5,
  parameter int unsigned RATE_W    = 16,
  parameter int unsigned END_SHIFT = ENV_END_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  release_envelope_stage_if.slave bus
);

  env_state_e         r_state;
  env_state_e         w_state_nxt;
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] w_shift_nxt;
  logic [SHIFT_W-1:0] w_shift_inc;
  logic               w_done_nxt;
  logic               w_clear;
  logic               w_tick;

  release_rate_divider #(.RATE_W(RATE_W)) u_rate_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_enable (r_state == RELEASE),
    .i_rate   (bus.rate),
    .o_tick_c (w_tick)
  );

  assign w_clear     = bus.gate_on || bus.start;
  assign w_shift_inc = r_shift + SHIFT_W'(1);

  // State register and shift level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next state: gate_on beats start beats tick
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    if (bus.gate_on) begin
      w_state_nxt = IDLE;
      w_shift_nxt = '0;
    end else if (bus.start) begin
      if (bus.start_level >= SHIFT_W'(END_SHIFT)) begin
        w_state_nxt = DONE;
        w_shift_nxt = SHIFT_W'(END_SHIFT);
        // A retrigger while already silent is not a new completion.
        w_done_nxt  = (r_state != DONE);
      end else begin
        w_state_nxt = RELEASE;
        w_shift_nxt = bus.start_level;
      end
    end else begin
      case (r_state)
        RELEASE: begin
          if (w_tick) begin
            w_shift_nxt = w_shift_inc;
            if (w_shift_inc == SHIFT_W'(END_SHIFT)) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        IDLE, DONE: ;
        default: begin
          w_state_nxt = IDLE;
          w_shift_nxt = '0;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.active      <= 1'b0;
      bus.end_release <= 1'b0;
      bus.done_pulse  <= 1'b0;
    end else begin
      bus.active      <= (w_state_nxt == RELEASE);
      bus.end_release <= (w_state_nxt == DONE);
      bus.done_pulse  <= w_done_nxt;
    end
  end

  // Datapath: attenuate with the shift in force before this cycle's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out <= (32'(r_shift) >= DATA_W) ? '0 : (bus.in >> r_shift);
      end
    end
  end

endmodule

// File: tb/tb_release_envelope_stage.sv
// Directed bench for release_envelope_stage with hand-computed expectations.
module tb_release_envelope_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_pulse;
  int   pulse_cyc;
  int   n_active;

  release_envelope_stage_if #(.DATA_W(20), .SHIFT_W(5), .RATE_W(16)) bus ();

  release_envelope_stage #(
    .DATA_W(20), .SHIFT_W(5), .RATE_W(16), .END_SHIFT(21)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.gate_on = 1'b0; bus.start_level = '0;
    bus.rate = '0; bus.in_valid = 1'b0; bus.in = '0;
    repeat (3) step();

    // Reset state
    check_val("rst_out",       32'(bus.out), 32'h0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_active",    32'(bus.active), 32'h0);
    check_val("rst_end",       32'(bus.end_release), 32'h0);
    check_val("rst_done",      32'(bus.done_pulse), 32'h0);

    // Pass-through in IDLE
    rst_n = 1'b1;
    step();
    bus.in_valid = 1'b1; bus.in = 20'hFFFFF;
    step();
    check_val("idle_out",       32'(bus.out), 32'hFFFFF);
    check_val("idle_out_valid", 32'(bus.out_valid), 32'h1);
    check_val("idle_active",    32'(bus.active), 32'h0);
    check_val("idle_end",       32'(bus.end_release), 32'h0);
    bus.in_valid = 1'b0; bus.in = 20'h11111;
    step();
    check_val("hold_out",       32'(bus.out), 32'hFFFFF);
    check_val("hold_out_valid", 32'(bus.out_valid), 32'h0);

    // Full release from level 2 at rate 3
    bus.in_valid = 1'b1; bus.in = 20'h80000;
    bus.start = 1'b1; bus.start_level = 5'd2; bus.rate = 16'd3;
    step();
    bus.start = 1'b0;
    check_val("rel_first_out", 32'(bus.out), 32'h80000);
    check_val("rel_active",    32'(bus.active), 32'h1);
    n_pulse = 0; pulse_cyc = 0;
    for (int k = 2; k <= 90; k++) begin
      step();
      if (bus.done_pulse) begin n_pulse++; pulse_cyc = k; end
      if (k == 2)  check_val("rel_k2",  32'(bus.out), 32'h20000);
      if (k == 5)  check_val("rel_k5",  32'(bus.out), 32'h20000);
      if (k == 6)  check_val("rel_k6",  32'(bus.out), 32'h10000);
      if (k == 10) check_val("rel_k10", 32'(bus.out), 32'h08000);
      if (k == 70) check_val("rel_k70", 32'(bus.out), 32'h00001);
      if (k == 76) check_val("rel_k76_active", 32'(bus.active), 32'h1);
    end
    check_val("rel_pulse_cnt", 32'(n_pulse), 32'd1);
    check_val("rel_pulse_cyc", 32'(pulse_cyc), 32'd77);
    check_val("rel_end",       32'(bus.end_release), 32'h1);
    check_val("rel_end_out",   32'(bus.out), 32'h0);
    check_val("rel_end_act",   32'(bus.active), 32'h0);

    // Return to IDLE, then start above END_SHIFT
    bus.gate_on = 1'b1;
    step();
    bus.gate_on = 1'b0;
    check_val("gate_end", 32'(bus.end_release), 32'h0);
    check_val("gate_act", 32'(bus.active), 32'h0);
    bus.start = 1'b1; bus.start_level = 5'd25;
    step();
    bus.start = 1'b0;
    check_val("hi_done_pulse", 32'(bus.done_pulse), 32'h1);
    check_val("hi_end",        32'(bus.end_release), 32'h1);
    check_val("hi_active",     32'(bus.active), 32'h0);
    n_pulse = 0; n_active = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.done_pulse) n_pulse++;
      if (bus.active) n_active++;
    end
    check_val("hi_out",        32'(bus.out), 32'h0);
    check_val("hi_extra_pulse", 32'(n_pulse), 32'd0);
    check_val("hi_active_cnt", 32'(n_active), 32'd0);

    // Retrigger mid-release: level 8 rate 3, reload to 4 at shift 10
    bus.gate_on = 1'b1;
    step();
    bus.gate_on = 1'b0;
    bus.start = 1'b1; bus.start_level = 5'd8; bus.rate = 16'd3;
    step();
    bus.start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      if (k == 9)  check_val("rt_k9",  32'(bus.out), 32'h00400);
      if (k == 10) check_val("rt_k10", 32'(bus.out), 32'h00200);
    end
    bus.start = 1'b1; bus.start_level = 5'd4;
    step();
    bus.start = 1'b0;
    check_val("rt_k11", 32'(bus.out), 32'h00200);
    for (int k = 12; k <= 16; k++) begin
      step();
      if (k == 12) check_val("rt_k12", 32'(bus.out), 32'h08000);
      if (k == 15) check_val("rt_k15", 32'(bus.out), 32'h08000);
      if (k == 16) check_val("rt_k16", 32'(bus.out), 32'h04000);
    end

    // gate_on and start together during RELEASE
    bus.gate_on = 1'b1; bus.start = 1'b1; bus.start_level = 5'd3;
    step();
    bus.gate_on = 1'b0; bus.start = 1'b0;
    check_val("gs_active", 32'(bus.active), 32'h0);
    check_val("gs_pulse",  32'(bus.done_pulse), 32'h0);
    bus.in = 20'h12345;
    step();
    check_val("gs_pass", 32'(bus.out), 32'h12345);
    check_val("gs_end",  32'(bus.end_release), 32'h0);

    // Async reset at shift 15 (level 8, rate 0)
    bus.in = 20'h80000;
    bus.start = 1'b1; bus.start_level = 5'd8; bus.rate = 16'd0;
    step();
    bus.start = 1'b0;
    for (int k = 2; k <= 8; k++) step();
    check_val("ar_pre_out", 32'(bus.out), 32'h00020);
    rst_n = 1'b0;
    #1;
    check_val("ar_out",       32'(bus.out), 32'h0);
    check_val("ar_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("ar_active",    32'(bus.active), 32'h0);
    check_val("ar_end",       32'(bus.end_release), 32'h0);
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_val("ar_novalid", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b1; bus.in = 20'hABCDE;
    step();
    check_val("ar_pass",    32'(bus.out), 32'hABCDE);
    check_val("ar_pass_act", 32'(bus.active), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
